// File: rtl/afifo_pkg.sv
// Shared constants and pointer type for both halves of the async FIFO.
package afifo_pkg;
  localparam int DFLT_ADDR_W = 3;
  localparam int PTR_W       = DFLT_ADDR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
endpackage

// File: rtl/write_module_gray2bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    for (int i = 0; i < W; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/write_module.sv
// Async FIFO write side: pointer, Gray export, full/almost_full/level from the synced read pointer.
// Optional sticky overflow flag and port when WRITE_OVF_EN is defined.
module write_module
  import afifo_pkg::*;
#(
  parameter int ADDR_W   = DFLT_ADDR_W,
  parameter int AF_LEVEL = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [ADDR_W:0]   rptr_sync,
  output logic [ADDR_W:0]   wptr,
  output logic [ADDR_W:0]   gray_wptr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_mem_en,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   level
`ifdef WRITE_OVF_EN
  ,
  output logic              overflow
`endif
);

  localparam int            PW     = ADDR_W + 1;
  localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);

  logic [PW-1:0] rptr_bin;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] gray_q, gray_d;
  logic [PW-1:0] fill_d;
  logic          af_q, af_d;

  gray2bin #(.W(PW)) u_gray2bin (
    .gray_i (rptr_sync),
    .bin_o  (rptr_bin)
  );

  // A stale read pointer can only under-report free space, so full stays pessimistic.
  assign full      = (wptr_q[ADDR_W] != rptr_bin[ADDR_W]) &&
                     (wptr_q[ADDR_W-1:0] == rptr_bin[ADDR_W-1:0]);
  assign wr_mem_en = wr & ~full;

  always_comb begin
    wptr_d = wptr_q + PW'(wr_mem_en);
    gray_d = (wptr_d >> 1) ^ wptr_d;
    fill_d = wptr_d - rptr_bin;
    af_d   = (fill_d >= AF_THR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      gray_q <= '0;
      af_q   <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      gray_q <= gray_d;
      af_q   <= af_d;
    end
  end

`ifdef WRITE_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (wr && full) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow = ovf_q;
`endif

  assign wptr        = wptr_q;
  assign gray_wptr   = gray_q;
  assign wr_addr     = wptr_q[ADDR_W-1:0];
  assign almost_full = af_q;
  assign level       = wptr_q - rptr_bin;

endmodule

// File: tb/tb_write_module.sv
// Bench for write_module (ADDR_W=3, AF_LEVEL=6): per-cycle scoreboard plus directed hand-computed checks.
module tb_write_module;

  logic       clk = 1'b0;
  logic       rst, wr;
  logic [3:0] rptr_sync;
  logic [3:0] wptr, gray_wptr, level;
  logic [2:0] wr_addr;
  logic       wr_mem_en, full, almost_full;
`ifdef WRITE_OVF_EN
  logic       overflow;
`endif

  always #5 clk = ~clk;

  write_module #(.ADDR_W(3), .AF_LEVEL(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr          (wr),
    .rptr_sync   (rptr_sync),
    .wptr        (wptr),
    .gray_wptr   (gray_wptr),
    .wr_addr     (wr_addr),
    .wr_mem_en   (wr_mem_en),
    .full        (full),
    .almost_full (almost_full),
    .level       (level)
`ifdef WRITE_OVF_EN
    ,
    .overflow    (overflow)
`endif
  );

  typedef struct {
    logic       wme;
    logic [2:0] addr;
    logic       full;
    logic [3:0] lvl;
    logic [3:0] wp;
    logic [3:0] gp;
    logic       af;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  int   errs   = 0;
  int   checks = 0;

  // Reference state: counts of accepted writes and read position, both mod 16.
  int wcnt, prc;
  bit m_af, m_ovf, pw, prst;

  function automatic logic [3:0] g(input int v);
    logic [3:0] b;
    b = v[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input bit w, input int rc, input bit r);
    exp_t e;
    int   occ;
    @(posedge clk);
    if (prst) begin
      wcnt  = 0;
      m_af  = 1'b0;
      m_ovf = 1'b0;
    end else begin
      occ = (wcnt - prc) & 15;
      if (pw && occ != 8) wcnt = (wcnt + 1) & 15;
      if (pw && occ == 8) m_ovf = 1'b1;
      m_af = (((wcnt - prc) & 15) >= 6);
    end
    #1;
    wr        = w;
    rst       = r;
    rptr_sync = g(rc);
    pw        = w;
    prst      = r;
    prc       = rc;
    occ       = (wcnt - rc) & 15;
    e.full    = (occ == 8);
    e.wme     = w && !e.full;
    e.addr    = wcnt[2:0];
    e.lvl     = occ[3:0];
    e.wp      = wcnt[3:0];
    e.gp      = g(wcnt);
    e.af      = m_af;
    e.ovf     = m_ovf;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_wr_mem_en", wr_mem_en, e.wme);
        chk("sb_wr_addr", wr_addr, e.addr);
        chk("sb_full", full, e.full);
        chk("sb_level", level, e.lvl);
        chk("sb_wptr", wptr, e.wp);
        chk("sb_gray_wptr", gray_wptr, e.gp);
        chk("sb_almost_full", almost_full, e.af);
`ifdef WRITE_OVF_EN
        chk("sb_overflow", overflow, e.ovf);
`endif
      end
    end
  end

  initial begin : stim
    rst = 1'b1; wr = 1'b0; rptr_sync = '0;
    prst = 1'b1; pw = 1'b0; prc = 0; wcnt = 0; m_af = 1'b0; m_ovf = 1'b0;

    step(0, 0, 1);
    step(0, 0, 0);
    chk("rst_wptr", wptr, 4'd0);
    chk("rst_gray", gray_wptr, 4'd0);
    chk("rst_af", almost_full, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_level", level, 4'd0);
    chk("rst_addr", wr_addr, 3'd0);

    // Fill to full with the reader parked at zero.
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0);
      chk("fill_addr", wr_addr, i);
      chk("fill_wme", wr_mem_en, 1'b1);
    end
    step(1, 0, 0);
    chk("full_flag", full, 1'b1);
    chk("full_level", level, 4'd8);
    chk("full_wptr", wptr, 4'b1000);
    chk("full_gray", gray_wptr, 4'b1100);
    chk("full_drop", wr_mem_en, 1'b0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("drop_wptr", wptr, 4'd8);
`ifdef WRITE_OVF_EN
    chk("ovf_sticky", overflow, 1'b1);
`endif

    // Write at full while the read pointer moves on the same edge.
    step(1, 0, 0);
    chk("race_drop", wr_mem_en, 1'b0);
    step(1, 1, 0);
    chk("race_next_wme", wr_mem_en, 1'b1);
    chk("race_next_full", full, 1'b0);
    step(0, 1, 0);
    chk("race_wptr", wptr, 4'd9);

    // almost_full timing.
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    step(0, 0, 0);
    chk("af_lvl5", level, 4'd5);
    chk("af_lvl5_af", almost_full, 1'b0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("af_set", almost_full, 1'b1);
    chk("af_lvl6", level, 4'd6);
    step(0, 2, 0);
    chk("af_rd_level", level, 4'd4);
    chk("af_rd_lag", almost_full, 1'b1);
    step(0, 2, 0);
    chk("af_clear", almost_full, 1'b0);

    // Pointer wrap: bring wptr to 15 with the reader at 10.
    for (int i = 0; i < 9; i++) step(1, 2 + i, 0);
    step(1, 10, 0);
    chk("wrap_pre_wptr", wptr, 4'd15);
    chk("wrap_pre_level", level, 4'd5);
    step(0, 10, 0);
    chk("wrap_wptr", wptr, 4'd0);
    chk("wrap_gray", gray_wptr, 4'd0);
    chk("wrap_level", level, 4'd6);
    chk("wrap_full", full, 1'b0);

    // Reset mid-burst at wptr = 5 with flags set.
    step(0, 13, 0);
    chk("burst_level", level, 4'd3);
    for (int i = 0; i < 5; i++) step(1, 13, 0);
    step(1, 13, 0);
    chk("burst_full", full, 1'b1);
    chk("burst_wptr", wptr, 4'd5);
    step(1, 0, 1);
    chk("burst_rst_wme", wr_mem_en, 1'b1);
    chk("burst_af", almost_full, 1'b1);
`ifdef WRITE_OVF_EN
    chk("burst_ovf", overflow, 1'b1);
`endif
    step(0, 0, 0);
    chk("mid_rst_wptr", wptr, 4'd0);
    chk("mid_rst_gray", gray_wptr, 4'd0);
    chk("mid_rst_af", almost_full, 1'b0);
    chk("mid_rst_level", level, 4'd0);
    chk("mid_rst_full", full, 1'b0);
`ifdef WRITE_OVF_EN
    chk("mid_rst_ovf", overflow, 1'b0);
`endif

    @(negedge clk);
    chk("sb_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/write_module.md
WRITE_MODULE -- requirements
Module: write_module

Interface
REQ-001 Parameter ADDR_W, default 3, memory address width; depth = 2**ADDR_W entries; pointers are ADDR_W+1 bits.
REQ-002 Parameter AF_LEVEL, default 6, fill level at or above which almost_full asserts; legal range 1..2**ADDR_W.
REQ-003 clk  input  1  single write-domain clock, rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wr  input  1  master write request; data is on the memory data bus this cycle.
REQ-006 rptr_sync  input  ADDR_W+1  Gray-coded read pointer, already double-flopped into the clk domain.
REQ-007 wptr  output  ADDR_W+1  binary write pointer, registered.
REQ-008 gray_wptr  output  ADDR_W+1  Gray-coded write pointer, registered, for export to the read domain.
REQ-009 wr_addr  output  ADDR_W  memory write address = wptr[ADDR_W-1:0].
REQ-010 wr_mem_en  output  1  memory write strobe, combinational.
REQ-011 full  output  1  FIFO full, combinational from registered state.
REQ-012 almost_full  output  1  fill level >= AF_LEVEL, registered.
REQ-013 level  output  ADDR_W+1  current fill level, combinational, 0..2**ADDR_W.
REQ-014 overflow  output  1  sticky flag for a write attempted while full (present only with WRITE_OVF_EN).

Function
REQ-015 rptr_bin = Gray-to-binary of rptr_sync: MSB copied, each lower bit = next-higher binary bit XOR its Gray bit.
REQ-016 full = (wptr[ADDR_W] != rptr_bin[ADDR_W]) and (wptr[ADDR_W-1:0] == rptr_bin[ADDR_W-1:0]).
REQ-017 wr_mem_en = wr and not full; a write while full is dropped; memory and pointers stay unchanged.
REQ-018 wptr_next = wptr + wr_mem_en, modulo 2**(ADDR_W+1); wptr <= wptr_next every cycle.
REQ-019 gray_wptr <= (wptr_next >> 1) XOR wptr_next every cycle, so gray_wptr always equals Gray(wptr) with no extra cycle of latency.
REQ-020 level = (wptr - rptr_bin) modulo 2**(ADDR_W+1).
REQ-021 almost_full <= ((wptr_next - rptr_bin) mod 2**(ADDR_W+1)) >= AF_LEVEL; it lags level by no cycle for own writes and by one cycle for read-pointer movement.
REQ-022 Pointer wrap: the pointer rolls over from 2**(ADDR_W+1)-1 to 0 with no glitch in full; the Gray code changes exactly one bit per increment.
REQ-023 A write and a read-pointer advance in the same cycle: full is evaluated from the pre-edge rptr_sync; the write is accepted if and only if full was 0.
REQ-024 A stale rptr_sync shall only make full/almost_full pessimistic, never optimistic; no write is ever accepted into an occupied slot.

Reset
REQ-025 On rst = 1 at a clk edge: wptr = 0, gray_wptr = 0, almost_full = 0, overflow = 0.
REQ-026 rst asserted during a burst: the in-flight write in that cycle is discarded (wr_mem_en is still combinational, but the pointer does not advance); the read domain must be reset together.
REQ-027 After reset with rptr_sync = 0: full = 0, level = 0, wr_addr = 0.

Configuration
REQ-028 Macro WRITE_OVF_EN: when defined, the overflow port and register exist; overflow <= 1 on any cycle where wr = 1 and full = 1, and it holds until rst.
REQ-029 Without WRITE_OVF_EN: the overflow port and its register are absent; dropped writes are silent; all other behaviour is identical.

Structure
REQ-030 Shared package afifo_pkg: the default ADDR_W and the pointer-width constant PTR_W = ADDR_W+1 as localparams, plus a pointer typedef; read_module and write_module shall both use it.
REQ-031 One sub-module gray2bin (parameterised width, combinational) performs REQ-015; it is reusable by the read side.

Verification (ADDR_W=3, AF_LEVEL=6)
REQ-032 Reset, then 8 writes with rptr_sync = 0: the cycles show wr_mem_en = 1 and wr_addr = 0..7; after the 8th write full = 1, level = 8, wptr = 4'b1000, gray_wptr = 4'b1100.
REQ-033 With full = 1, hold wr = 1 for 3 cycles: wr_mem_en = 0 and wptr stays 8; with WRITE_OVF_EN, overflow = 1 and stays 1 afterwards.
REQ-034 Level 5, then one write: almost_full = 1 on the next cycle; rptr_sync advances to Gray(2): almost_full = 0 one cycle later, level = 4.
REQ-035 Wrap: drive reads and writes to wptr = 15, rptr_bin = 10, then write: wptr = 0, gray_wptr = 0, level = 6, full = 0.
REQ-036 At full, rptr_sync advances by 1 in the same cycle as wr = 1: that write is dropped; the next wr is accepted.
REQ-037 Assert rst mid-burst at wptr = 5: the next cycle shows wptr = 0, gray_wptr = 0, almost_full = 0, overflow = 0.
